// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: HI/LO op codes
// (also used by the decoder), FSM state encoding, default latencies and
// the counter-width helper.
package md_pkg;

  localparam int unsigned HILO_W = 11;

  localparam logic [HILO_W-1:0] Hilo_none  = 11'd0;
  localparam logic [HILO_W-1:0] Hilo_mult  = 11'd1;
  localparam logic [HILO_W-1:0] Hilo_multu = 11'd2;
  localparam logic [HILO_W-1:0] Hilo_div   = 11'd3;
  localparam logic [HILO_W-1:0] Hilo_divu  = 11'd4;
  localparam logic [HILO_W-1:0] Hilo_ToHi  = 11'd5;
  localparam logic [HILO_W-1:0] Hilo_ToLo  = 11'd6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Bits needed to hold the larger of the two latencies.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Produces the 64-bit {hi, lo}
// result for the selected op and flags a zero divisor on DIV/DIVU.
module md_arith
  import md_pkg::*;
(
  input  logic [HILO_W-1:0] op_i,
  input  logic [31:0]       rs_i,
  input  logic [31:0]       rt_i,
  output logic [63:0]       res_o,
  output logic              div_zero_o
);

  logic [63:0] rs_sx_s;
  logic [63:0] rt_sx_s;
  logic [63:0] rs_zx_s;
  logic [63:0] rt_zx_s;

  assign rs_sx_s = {{32{rs_i[31]}}, rs_i};
  assign rt_sx_s = {{32{rt_i[31]}}, rt_i};
  assign rs_zx_s = {32'd0, rs_i};
  assign rt_zx_s = {32'd0, rt_i};

  // Select the arithmetic result; the INT_MIN / -1 overflow case is fixed explicitly.
  always_comb begin
    res_o      = 64'd0;
    div_zero_o = 1'b0;
    case (op_i)
      Hilo_mult:  res_o = rs_sx_s * rt_sx_s;
      Hilo_multu: res_o = rs_zx_s * rt_zx_s;
      Hilo_div: begin
        if (rt_i == 32'd0) begin
          div_zero_o = 1'b1;
        end else if ((rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF)) begin
          res_o = {32'd0, 32'h8000_0000};
        end else begin
          res_o = {32'($signed(rs_i) % $signed(rt_i)), 32'($signed(rs_i) / $signed(rt_i))};
        end
      end
      Hilo_divu: begin
        if (rt_i == 32'd0) begin
          div_zero_o = 1'b1;
        end else begin
          res_o = {rs_i % rt_i, rs_i / rt_i};
        end
      end
      default: res_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_seq.sv
// Multiply/divide sequencer owning HI/LO. Launches MULT/MULTU/DIV/DIVU,
// holds busy for a fixed latency, then commits the pending result.
// Services MTHI/MTLO in IDLE. Optional E-stage flush input `cancel` is
// enabled by defining MD_CANCEL_EN.
module md_seq
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef MD_CANCEL_EN
  input  logic              cancel,
`endif
  input  logic [HILO_W-1:0] hiloop,
  input  logic              start,
  input  logic [31:0]       rs,
  input  logic [31:0]       rt,
  output logic              busy,
  output logic [31:0]       hi,
  output logic [31:0]       lo
);

  localparam int unsigned   CNT_W     = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      res_hi_q;
  logic [31:0]      res_lo_q;
  logic             res_zero_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             busy_q;

  logic             cancel_s;
  logic             is_mul_s;
  logic             is_div_s;
  logic             launch_s;
  logic             mthi_s;
  logic             mtlo_s;
  logic [CNT_W-1:0] cnt_d;
  logic [63:0]      arith_res_s;
  logic             div_zero_s;

`ifdef MD_CANCEL_EN
  assign cancel_s = cancel;
`else
  assign cancel_s = 1'b0;
`endif

  md_arith u_arith (
    .op_i       (hiloop),
    .rs_i       (rs),
    .rt_i       (rt),
    .res_o      (arith_res_s),
    .div_zero_o (div_zero_s)
  );

  // Decode which request is accepted this cycle; anything while BUSY is dropped.
  always_comb begin
    is_mul_s = (hiloop == Hilo_mult) || (hiloop == Hilo_multu);
    is_div_s = (hiloop == Hilo_div)  || (hiloop == Hilo_divu);
    launch_s = 1'b0;
    mthi_s   = 1'b0;
    mtlo_s   = 1'b0;
    if ((state_q == S_IDLE) && !cancel_s) begin
      launch_s = start && (is_mul_s || is_div_s);
      mthi_s   = (hiloop == Hilo_ToHi);
      mtlo_s   = (hiloop == Hilo_ToLo);
    end else begin
      launch_s = 1'b0;
    end
    if (is_div_s) begin
      cnt_d = DIV_LOAD;
    end else begin
      cnt_d = MULT_LOAD;
    end
  end

  // Sequencer FSM: launch, count down the latency, commit HI/LO, handle MT writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      res_hi_q   <= 32'd0;
      res_lo_q   <= 32'd0;
      res_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (launch_s) begin
            res_hi_q   <= arith_res_s[63:32];
            res_lo_q   <= arith_res_s[31:0];
            res_zero_q <= div_zero_s;
            cnt_q      <= cnt_d;
            busy_q     <= 1'b1;
            state_q    <= S_BUSY;
          end else begin
            if (mthi_s) hi_q <= rs;
            if (mtlo_s) lo_q <= rs;
          end
        end
        S_BUSY: begin
          // A zero count here is unreachable; treating it as the last cycle avoids lock-up.
          if (cnt_q <= CNT_ONE) begin
            if (!res_zero_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/md_seq.md
# md_seq

Multiply/divide sequencer owning the HI/LO registers. Sits in E stage beside the ALU, fed by decoder outputs `hiloop` and `E_start`. On issue it launches MULT/MULTU/DIV/DIVU, holds `busy` for a fixed latency, then commits the result to HI/LO. It also services MTHI/MTLO writes and drives HI/LO back for MFHI/MFLO forwarding. The hazard unit stalls D whenever a HI/LO-using instruction meets `E_start | busy`.

## Interface
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU, ≥1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU, ≥1.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `hiloop`  in  11: E-stage op code, from package `md_pkg` (`Hilo_mult`, `Hilo_multu`, `Hilo_div`, `Hilo_divu`, `Hilo_ToHi`, `Hilo_ToLo`; 0 = none).
- `start`  in  1: `E_start`, high for one E cycle with a mult/div op.
- `rs`  in  32: forwarded rs operand (dividend / multiplicand / MT data).
- `rt`  in  32: forwarded rt operand (divisor / multiplier).
- `busy`  out  1: operation in flight.
- `hi`  out  32: architectural HI.
- `lo`  out  32: architectural LO.
- `cancel`  in  1: present only with `MD_CANCEL_EN`.

## Operation
- States: IDLE, BUSY. Internal: `cnt` (4 bits by default, sized from max latency), `res_hi`/`res_lo` (pending result).
- IDLE + `start`: latch `res_hi`/`res_lo` from combinational arithmetic on `rs`/`rt`. Load `cnt` = MULT_CYCLES or DIV_CYCLES. Go BUSY.
- BUSY: `cnt` decrements each cycle. At the edge where `cnt` == 1: HI←`res_hi`, LO←`res_lo`, go IDLE.
- MULT: signed 64-bit product. MULTU: unsigned. HI = [63:32], LO = [31:0].
- DIV: LO = quotient truncated toward zero, HI = remainder with the dividend's sign. 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU: unsigned quotient/remainder.
- Divisor 0 (DIV/DIVU): operation still runs its full busy time. HI/LO remain unchanged at commit.
- `Hilo_ToHi`/`Hilo_ToLo` in IDLE: HI or LO ← `rs` at that edge; no busy.
- Any `start` or MT op while BUSY is illegal (hazard unit prevents it). It is ignored, and the in-flight op completes.
- `start` with a non-mult/div `hiloop` is ignored.
- Reset (any time, including mid-operation): state IDLE, `busy` 0, `cnt` 0, `hi`/`lo`/pending all 0.

## Timing
- `start` sampled at edge k → `busy` high in cycles k+1 … k+N (N = configured latency).
- New HI/LO are visible in cycle k+N+1, the same cycle `busy` falls.
- MT write at edge k → new value visible in cycle k+1.
- `hi`/`lo` are registered outputs with no combinational path from inputs.
- `busy` is registered (high exactly when state = BUSY).
- Back-to-back: a second `start` is accepted in the first cycle `busy` is low.

## Configuration
- `MD_CANCEL_EN` defined:
  - Adds the `cancel` input (E-stage flush on exception).
  - `cancel` with `start` at the same edge: the op is not launched.
  - `cancel` with MT: the write is suppressed.
  - `cancel` while BUSY has no effect, since the issuing instruction has already passed E.
- Undefined: the port is absent and every `start`/MT is accepted.

## Structure
- `md_pkg` holds:
  - `Hilo_*` op codes, shared with the decoder.
  - State encoding.
  - Default latencies.
  - `cnt` width derived from max(MULT_CYCLES, DIV_CYCLES).
- Sub-module `md_arith`: purely combinational. Takes op, `rs`, `rt`; returns 64-bit {hi, lo} and a `div_zero` flag. The sequencer contains only state, counter and registers.

## Test plan
- Reset mid-DIV:
  - Stimulus: `reset_n` low in cycle 3 of BUSY.
  - Response: `busy`=0, `hi`=`lo`=0 immediately. No later commit occurs.
- MULT signed:
  - Stimulus: `rs`=0xFFFFFFFE (-2), `rt`=3, `start` at edge k.
  - Response: `busy` high cycles k+1..k+5. `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA from cycle k+6.
- MULTU:
  - Stimulus: `rs`=`rt`=0xFFFFFFFF.
  - Response: `hi`=0xFFFFFFFE, `lo`=0x00000001 after 5 busy cycles.
- DIV signed:
  - Stimulus: `rs`=-7 (0xFFFFFFF9), `rt`=2.
  - Response: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF after 10 busy cycles.
  - Repeat with `rt`=0: `hi`/`lo` unchanged, `busy` still 10 cycles.
- MT and illegal-while-busy:
  - Stimulus: MTHI 0x1234 in IDLE.
  - Response: `hi`=0x1234 next cycle.
  - Stimulus: MTLO issued while BUSY.
  - Response: ignored; pending result commits normally.
- With `MD_CANCEL_EN`:
  - Stimulus: `start`+`cancel` at the same edge.
  - Response: `busy` stays 0, `hi`/`lo` unchanged.
